// File: rtl/cf_fft_pkg.sv
// Shared constants, state encodings and helpers for the FFT output reorder buffer.
// Frame length is 2**N_LOG2 complex samples of DW-bit real/imag parts.
package cf_fft_pkg;

  localparam int N_LOG2 = 10;
  localparam int DW     = 16;

  typedef enum logic { W_IDLE, W_FILL } w_state_e;
  typedef enum logic { R_IDLE, R_RUN  } r_state_e;

  // One output sample with its framing flags and source bank.
  typedef struct packed {
    logic          bank;
    logic          sop;
    logic          eop;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } skid_entry_t;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] idx);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = idx[N_LOG2-1-i];
    return r;
  endfunction

endpackage

// File: rtl/cf_fft_1024_8_reorder_ram.sv
// Ping-pong frame memory: two banks addressed by {bank, index}.
// Synchronous write, registered read with one cycle of latency.
module cf_fft_1024_8_reorder_ram
  import cf_fft_pkg::*;
(
  input  logic                clock_c,
  input  logic                wr_en,
  input  logic [N_LOG2:0]     wr_addr,
  input  logic [2*DW-1:0]     wr_data,
  input  logic                rd_en,
  input  logic [N_LOG2:0]     rd_addr,
  output logic [2*DW-1:0]     rd_data
);

  logic [2*DW-1:0] mem_q [2**(N_LOG2+1)];

  // NOTE: the storage array carries no reset; validity is tracked by the bank full flags.
  always_ff @(posedge clock_c) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/cf_fft_1024_8_reorder.sv
// Reorders the FFT's bit-reversed output stream into natural order frames,
// delivered over a valid/ready handshake through a 2-entry skid buffer.
module cf_fft_1024_8_reorder
  import cf_fft_pkg::*;
(
  input  logic          clock_c,
  input  logic          reset_n,
  input  logic          in_start,
  input  logic          in_en,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          overflow,
  output logic          abort
);

  w_state_e          w_state_q, w_state_d;
  logic              wbank_q, wbank_d;
  logic [N_LOG2-1:0] wcnt_q, wcnt_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              abort_q, abort_d;

  r_state_e          r_state_q, r_state_d;
  logic              rbank_q, rbank_d;
  logic [N_LOG2-1:0] rcnt_q, rcnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              pend_bank_q, pend_bank_d;
  logic              pend_sop_q, pend_sop_d;
  logic              pend_eop_q, pend_eop_d;

  skid_entry_t       skid0_q, skid0_d, skid1_q, skid1_d, push_entry;
  logic [1:0]        skid_cnt_q, skid_cnt_d;

  logic              wr_en, rd_en, rd_go, rd_room, pop;
  logic [N_LOG2:0]   wr_addr, rd_addr;
  logic [2*DW-1:0]   rd_data;
  logic [1:0]        set_mask, clr_mask, full_vis;
  logic [2:0]        occ;

  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_sop   = out_valid & skid0_q.sop;
  assign out_eop   = out_valid & skid0_q.eop;
  assign out_re    = skid0_q.re;
  assign out_im    = skid0_q.im;
  assign overflow  = overflow_q;
  assign abort     = abort_q;

  assign pop = out_valid & out_ready;

  // A bank freed by this cycle's EOP is already visible to the writer.
  always_comb begin
    clr_mask = 2'b00;
    if (pop && skid0_q.eop) clr_mask[skid0_q.bank] = 1'b1;
    full_vis = full_q & ~clr_mask;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_d  = w_state_q;
    wbank_d    = wbank_q;
    wcnt_d     = wcnt_q;
    set_mask   = 2'b00;
    overflow_d = 1'b0;
    abort_d    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = {wbank_q, bitrev(wcnt_q)};
    if (in_en && in_start) begin
      abort_d = (w_state_q == W_FILL);
      if (full_vis[wbank_q]) begin
        overflow_d = 1'b1;
        w_state_d  = W_IDLE;
        wcnt_d     = '0;
      end else begin
        wr_en     = 1'b1;
        wr_addr   = {wbank_q, {N_LOG2{1'b0}}};
        wcnt_d    = N_LOG2'(1);
        w_state_d = W_FILL;
      end
    end else if (in_en && (w_state_q == W_FILL)) begin
      wr_en  = 1'b1;
      wcnt_d = wcnt_q + N_LOG2'(1);
      if (wcnt_q == '1) begin
        set_mask[wbank_q] = 1'b1;
        wbank_d           = ~wbank_q;
        w_state_d         = W_IDLE;
      end
    end
  end

  // Reading may begin alongside the final write: index 0 was written first and
  // the last-written word (index 1023) is the last one read.
  always_comb begin
    r_state_d   = r_state_q;
    rbank_d     = rbank_q;
    rcnt_d      = rcnt_q;
    rd_pend_d   = 1'b0;
    pend_bank_d = pend_bank_q;
    pend_sop_d  = pend_sop_q;
    pend_eop_d  = pend_eop_q;
    rd_en       = 1'b0;
    rd_addr     = {rbank_q, rcnt_q};
    occ         = 3'(skid_cnt_q) + 3'(rd_pend_q) - 3'(pop);
    rd_room     = (occ <= 3'd1);
    rd_go       = (r_state_q == R_RUN) || full_q[rbank_q] || set_mask[rbank_q];
    if (rd_go) begin
      r_state_d = R_RUN;
      if (rd_room) begin
        rd_en       = 1'b1;
        rd_pend_d   = 1'b1;
        pend_bank_d = rbank_q;
        pend_sop_d  = (rcnt_q == '0);
        pend_eop_d  = (rcnt_q == '1);
        rcnt_d      = rcnt_q + N_LOG2'(1);
        if (rcnt_q == '1) begin
          rbank_d   = ~rbank_q;
          r_state_d = R_IDLE;
        end
      end
    end
  end

  always_comb begin
    push_entry.bank = pend_bank_q;
    push_entry.sop  = pend_sop_q;
    push_entry.eop  = pend_eop_q;
    push_entry.re   = rd_data[2*DW-1:DW];
    push_entry.im   = rd_data[DW-1:0];
    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (pop) begin
      skid0_d    = skid1_q;
      skid_cnt_d = skid_cnt_d - 2'd1;
    end
    if (rd_pend_q) begin
      if (skid_cnt_d == 2'd0) skid0_d = push_entry;
      else                    skid1_d = push_entry;
      skid_cnt_d = skid_cnt_d + 2'd1;
    end
    full_d = (full_q & ~clr_mask) | set_mask;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q   <= W_IDLE;
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      full_q      <= 2'b00;
      overflow_q  <= 1'b0;
      abort_q     <= 1'b0;
      r_state_q   <= R_IDLE;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      rd_pend_q   <= 1'b0;
      pend_bank_q <= 1'b0;
      pend_sop_q  <= 1'b0;
      pend_eop_q  <= 1'b0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= 2'd0;
    end else begin
      w_state_q   <= w_state_d;
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      abort_q     <= abort_d;
      r_state_q   <= r_state_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      rd_pend_q   <= rd_pend_d;
      pend_bank_q <= pend_bank_d;
      pend_sop_q  <= pend_sop_d;
      pend_eop_q  <= pend_eop_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  cf_fft_1024_8_reorder_ram u_ram (
    .clock_c (clock_c),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_cf_fft_1024_8_reorder.sv
// Bench for the reorder buffer: random data and handshake stimulus scored
// against a frame-level model of which frames are kept and in what order.
module tb_cf_fft_1024_8_reorder;

  localparam int NPTS = 1024;

  logic        clock_c = 1'b0;
  logic        reset_n;
  logic        in_start, in_en;
  logic [15:0] in_re, in_im;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [15:0] out_re, out_im;
  logic        overflow, abort;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frames being assembled and samples still owed downstream.
  logic [33:0] exp_q[$];
  logic [31:0] cur [NPTS];
  int          pos = 0;
  bit          filling = 0;
  int          held = 0;
  bit          exp_ovf = 0, exp_abt = 0;
  bit          prev_stall = 0;
  logic [34:0] prev_out;
  logic [33:0] e;
  int          acc_cnt = 0, ovf_seen = 0, abt_seen = 0;
  int          ready_mode = 0;
  int          base, w, nvalid;

  cf_fft_1024_8_reorder dut (
    .clock_c   (clock_c),
    .reset_n   (reset_n),
    .in_start  (in_start),
    .in_en     (in_en),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_re    (out_re),
    .out_im    (out_im),
    .overflow  (overflow),
    .abort     (abort)
  );

  always #5 clock_c = ~clock_c;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int tb_bitrev(input int v);
    int r = 0;
    for (int i = 0; i < 10; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clock_c);
    #1;
  endtask

  // Drives nsamp samples of one frame; ramp data puts k at arrival position bitrev(k).
  task automatic send_frame(input bit ramp, input int nsamp, input int gap_pct);
    int k;
    for (int p = 0; p < nsamp; p++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_en = 1'b0; in_start = 1'b0;
        tick();
      end
      in_en    = 1'b1;
      in_start = (p == 0);
      if (ramp) begin
        k     = tb_bitrev(p);
        in_re = 16'(k);
        in_im = 16'(-k);
      end else begin
        in_re = 16'($urandom);
        in_im = 16'($urandom);
      end
      tick();
    end
    in_en = 1'b0; in_start = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(negedge clock_c);
      n++;
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_idle"}, out_valid, 1'b0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    held = 0; filling = 0; pos = 0;
    exp_ovf = 0; exp_abt = 0; prev_stall = 0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock_c);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  always @(negedge clock_c) begin
    if (reset_n) begin
      if (prev_stall)
        check("hold_stable", {out_valid, out_sop, out_eop, out_re, out_im}, prev_out);
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_sop, out_eop, out_re, out_im};
      check("overflow_pulse", overflow, exp_ovf);
      check("abort_pulse", abort, exp_abt);
      if (overflow) ovf_seen++;
      if (abort) abt_seen++;
      exp_ovf = 0; exp_abt = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("sample", {out_sop, out_eop, out_re, out_im}, e);
          acc_cnt++;
          if (e[32]) held--;
        end
      end
      if (in_en && in_start) begin
        if (filling) exp_abt = 1;
        if (held == 2) begin
          exp_ovf = 1;
          filling = 0;
        end else begin
          cur[0]  = {in_re, in_im};
          pos     = 1;
          filling = 1;
        end
      end else if (in_en && filling) begin
        cur[pos] = {in_re, in_im};
        pos++;
        if (pos == NPTS) begin
          for (int k = 0; k < NPTS; k++)
            exp_q.push_back({(k == 0), (k == NPTS-1), cur[tb_bitrev(k)]});
          held++;
          filling = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_start = 1'b0; in_en = 1'b0; in_re = '0; in_im = '0;
    #1;
    check("reset_outputs", {out_valid, out_sop, out_eop, out_re, out_im, overflow, abort}, '0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_outputs", {out_valid, overflow, abort}, '0);

    // Ramp frame, ready high: natural order and two-cycle latency.
    ready_mode = 1;
    tick();
    base = acc_cnt;
    send_frame(1'b1, NPTS, 0);
    @(negedge clock_c);
    check("lat_t1_valid", out_valid, 1'b0);
    @(negedge clock_c);
    check("lat_t2_valid", out_valid, 1'b1);
    check("lat_t2_sop", {out_sop, out_re}, {1'b1, 16'd0});
    wait_drain("ramp", 3000);
    check("ramp_count", acc_cnt - base, NPTS);

    // Three back-to-back frames: continuous output, no overflow.
    base = ovf_seen;
    fork
      begin
        send_frame(1'b0, NPTS, 0);
        send_frame(1'b0, NPTS, 0);
        send_frame(1'b0, NPTS, 0);
      end
      begin
        w = 0;
        @(negedge clock_c);
        while (!out_valid && w < 4000) begin @(negedge clock_c); w++; end
        nvalid = 0;
        for (int i = 0; i < 3*NPTS; i++) begin
          if (out_valid) nvalid++;
          @(negedge clock_c);
        end
      end
    join
    check("b2b_valid_cycles", nvalid, 3*NPTS);
    check("b2b_no_overflow", ovf_seen - base, 0);
    wait_drain("b2b", 3000);

    // Ready low while two frames arrive; the third frame is dropped.
    ready_mode = 0;
    tick();
    base = ovf_seen;
    send_frame(1'b0, NPTS, 0);
    send_frame(1'b0, NPTS, 0);
    send_frame(1'b0, NPTS, 0);
    repeat (4) tick();
    check("ovf_once", ovf_seen - base, 1);
    ready_mode = 1;
    wait_drain("ovf", 5000);

    // Random ready and random input gaps.
    ready_mode = 2;
    base = acc_cnt;
    send_frame(1'b0, NPTS, 30);
    send_frame(1'b1, NPTS, 30);
    wait_drain("rand", 9000);
    check("rand_count", acc_cnt - base, 2*NPTS);

    // Restarted frame: the partial one is discarded.
    ready_mode = 1;
    base = abt_seen;
    w = acc_cnt;
    send_frame(1'b0, 500, 0);
    send_frame(1'b0, NPTS, 0);
    wait_drain("abort", 3000);
    check("abort_once", abt_seen - base, 1);
    check("abort_count", acc_cnt - w, NPTS);

    // Reset during readout.
    base = acc_cnt;
    send_frame(1'b1, NPTS, 0);
    w = 0;
    while (acc_cnt < base + 300 && w < 2000) begin @(negedge clock_c); w++; end
    check("mid_read_reached", acc_cnt >= base + 300, 1'b1);
    #1;
    reset_n = 1'b0;
    flush_model();
    #1;
    check("mid_reset_outputs", {out_valid, out_sop, out_eop, out_re, out_im, overflow, abort}, '0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("no_out_after_reset", out_valid, 1'b0);
    base = acc_cnt;
    send_frame(1'b1, NPTS, 0);
    wait_drain("post_reset", 3000);
    check("post_reset_count", acc_cnt - base, NPTS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
